// File: rtl/seg_scan_if.sv
// Scan-controller bus: enable/mask in, digit select, anodes and frame tick out.
interface seg_scan_if;
  logic       i_en;
  logic [3:0] i_digit_mask;
  logic [1:0] o_ctrl;
  logic [3:0] o_anode;
  logic       o_frame_tick;

  modport master (output i_en, i_digit_mask, input o_ctrl, o_anode, o_frame_tick);
  modport slave  (input i_en, i_digit_mask, output o_ctrl, o_anode, o_frame_tick);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Digit-scan controller for a 4-digit multiplexed 7-segment display: blanked
// slots, masked-digit skipping and a frame tick on every wrap of the scan.
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV          = 50000,
  parameter int unsigned BLANK_CYCLES     = 2,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  seg_scan_if.slave  scan_if
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [3:0] ANODE_OFF = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [1:0]       nxt_idx;
  logic [3:0]       anode_q, anode_d;
  logic             tick_q, tick_d;
  logic             lit_q, lit_d;
  logic             scan_ok;

  function automatic logic [3:0] anode_on(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    return ANODE_ACTIVE_LOW ? ~oh : oh;
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  // First enabled digit strictly above cur, wrapping; falls back to cur itself.
  function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = cur;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = cur + 2'(k);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= 2'd0;
      anode_q <= ANODE_OFF;
      tick_q  <= 1'b0;
      lit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
      lit_q   <= lit_d;
    end
  end

  // lit tracks whether the current slot's digit stayed enabled; once cleared it
  // keeps the anode dark until the next slot boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    anode_d = ANODE_OFF;
    tick_d  = 1'b0;
    lit_d   = lit_q;
    cnt_inc = cnt_q + CNT_W'(1);
    nxt_idx = next_idx(ctrl_q, scan_if.i_digit_mask);
    scan_ok = scan_if.i_en && (scan_if.i_digit_mask != 4'b0000);

    if (!scan_ok) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          ctrl_d  = lowest_idx(scan_if.i_digit_mask);
          lit_d   = 1'b1;
        end
        ST_BLANK, ST_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            ctrl_d  = nxt_idx;
            tick_d  = (nxt_idx <= ctrl_q);
            lit_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            lit_d = lit_q & scan_if.i_digit_mask[ctrl_q];
            if (cnt_inc >= CNT_BLANK) begin
              state_d = ST_DRIVE;
              if (lit_d) anode_d = anode_on(ctrl_q);
            end else begin
              state_d = ST_BLANK;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign scan_if.o_ctrl       = ctrl_q;
  assign scan_if.o_anode      = anode_q;
  assign scan_if.o_frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a slot-level reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned BLANK   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if sif ();

  seg_scan_ctrl #(
    .CLK_DIV          (CLK_DIV),
    .BLANK_CYCLES     (BLANK),
    .ANODE_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .scan_if (sif)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: scanning flag, current digit, position in slot, lit flag.
  bit m_scan = 1'b0;
  int m_digit = 0;
  int m_pos = 0;
  bit m_lit = 1'b0;
  bit m_tick = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [3:0] mask;
    int nd;
    mask = sif.i_digit_mask;
    if (rst) begin
      m_scan = 0; m_digit = 0; m_pos = 0; m_lit = 0; m_tick = 0;
    end else if (!sif.i_en || mask == 4'b0000) begin
      m_scan = 0; m_pos = 0; m_tick = 0;
    end else if (!m_scan) begin
      m_scan = 1; m_pos = 0; m_lit = 1; m_tick = 0;
      m_digit = -1;
      for (int d = 0; d < 4; d++) if (m_digit < 0 && mask[d]) m_digit = d;
    end else if (m_pos == CLK_DIV - 1) begin
      nd = -1;
      for (int k = 1; k <= 4; k++) if (nd < 0 && mask[(m_digit + k) % 4]) nd = (m_digit + k) % 4;
      m_tick  = (nd <= m_digit);
      m_digit = nd;
      m_pos   = 0;
      m_lit   = 1;
    end else begin
      m_pos++;
      m_lit  = m_lit && mask[m_digit];
      m_tick = 0;
    end
  endtask

  task automatic compare_all();
    logic [3:0] ea;
    ea = 4'hF;
    if (m_scan && m_pos >= BLANK && m_lit) ea = ~(4'b0001 << m_digit);
    check("ctrl", 32'(sif.o_ctrl), 32'(m_digit));
    check("anode", 32'(sif.o_anode), 32'(ea));
    check("tick", 32'(sif.o_frame_tick), 32'(m_tick));
    check("one_hot", 32'($countones(~sif.o_anode) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic run_until(input int d, input int p);
    int guard;
    guard = 0;
    while (!(m_scan && m_digit == d && m_pos == p) && guard < 200) begin
      step();
      guard++;
    end
    check("nav_ctrl", 32'(sif.o_ctrl), 32'(d));
  endtask

  initial begin
    int first_tick;
    rst = 1'b1;
    sif.i_en = 1'b0;
    sif.i_digit_mask = 4'b0000;
    step();
    step();
    check("rst_ctrl", 32'(sif.o_ctrl), 32'd0);
    check("rst_anode", 32'(sif.o_anode), 32'hF);
    check("rst_tick", 32'(sif.o_frame_tick), 32'd0);

    // Full four-digit scan
    rst = 1'b0;
    sif.i_en = 1'b1;
    sif.i_digit_mask = 4'b1111;
    first_tick = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (sif.o_frame_tick && first_tick < 0) first_tick = i;
      if (i == 2)  check("p1_blank", 32'(sif.o_anode), 32'hF);
      if (i == 3)  check("p1_anode_s0", 32'(sif.o_anode), 32'b1110);
      if (i == 9)  check("p1_ctrl_s1", 32'(sif.o_ctrl), 32'd1);
      if (i == 11) check("p1_anode_s1", 32'(sif.o_anode), 32'b1101);
    end
    check("p1_first_tick", 32'(first_tick), 32'd33);

    // Alternate digits 1 and 3
    sif.i_digit_mask = 4'b1010;
    for (int i = 0; i < 48; i++) begin
      step();
      check("p2_no_d0d2", 32'(~sif.o_anode & 4'b0101), 32'd0);
    end

    // Single digit: ticks every slot
    sif.i_digit_mask = 4'b0100;
    for (int i = 0; i < 24; i++) begin
      step();
      if (m_digit == 2 && m_pos == 2) check("p3_anode", 32'(sif.o_anode), 32'b1011);
    end

    // Enable dropped mid-slot, then restart
    sif.i_digit_mask = 4'b1111;
    run_until(1, 5);
    sif.i_en = 1'b0;
    step();
    check("p4_anode_off", 32'(sif.o_anode), 32'hF);
    check("p4_ctrl_hold", 32'(sif.o_ctrl), 32'd1);
    sif.i_en = 1'b1;
    step();
    check("p4_restart_ctrl", 32'(sif.o_ctrl), 32'd0);
    check("p4_restart_tick", 32'(sif.o_frame_tick), 32'd0);

    // Current digit masked mid-slot
    run_until(2, 4);
    sif.i_digit_mask = 4'b1011;
    step();
    check("p5_anode_off", 32'(sif.o_anode), 32'hF);
    step();
    step();
    check("p5_ctrl_hold", 32'(sif.o_ctrl), 32'd2);
    step();
    check("p5_ctrl_next", 32'(sif.o_ctrl), 32'd3);

    // Reset mid-slot
    sif.i_digit_mask = 4'b1111;
    run_until(3, 3);
    rst = 1'b1;
    step();
    check("p6_rst_ctrl", 32'(sif.o_ctrl), 32'd0);
    check("p6_rst_anode", 32'(sif.o_anode), 32'hF);
    check("p6_rst_tick", 32'(sif.o_frame_tick), 32'd0);
    rst = 1'b0;

    // Random mask/enable/reset traffic
    for (int i = 0; i < 1000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      sif.i_en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) sif.i_digit_mask = 4'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
